// File: rtl/ballot_pkg.sv
// ballot_pkg: shared types and constants for the voter-side ballot unit.
//   state_e      : ballot FSM states (IDLE, ARMED, CAST, HOLD)
//   CAND_*       : bit index of each candidate in button/strobe vectors
//   NUM_BUTTONS  : number of voter push-buttons
//   count_high() : number of asserted bits in a button vector
package ballot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        CAST  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam int NUM_BUTTONS = 4;

    localparam int CAND_P1   = 0;
    localparam int CAND_P2   = 1;
    localparam int CAND_P3   = 2;
    localparam int CAND_NOTA = 3;

    function automatic logic [2:0] count_high(input logic [NUM_BUTTONS-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/ballot_debounce.sv
// ballot_debounce: two-flop synchronizer followed by a stability counter.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   btn_i   : raw asynchronous button level
//   level_o : debounced level; changes only after DEBOUNCE_CYCLES consecutive
//             synchronized samples that disagree with the current level
module ballot_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Any sample agreeing with the current level restarts the count, so only
    // an unbroken run of disagreeing samples can flip the output.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/ballot_unit.sv
// ballot_unit: voter-side front end. Debounces four buttons and accepts
// exactly one vote per ballot release, then locks out until the buttons are
// released and the hold time has elapsed.
//   CLK, CLEAR_N                 : clock, asynchronous active-low reset
//   ENABLE                       : ballot release (level, sampled per cycle)
//   BTN_P1/P2/P3/NOTA            : raw active-high buttons
//   P1/P2/P3/NOTA                : registered one-cycle vote strobes
//   READY / BUSY                 : armed lamp / vote-recorded lockout lamp
//   ERR_MULTI                    : sticky multi-press flag, cleared on next release
//   TIMEOUT                      : one-cycle pulse when an armed ballot expires
// Optional feature: define VOTE_TIMEOUT_EN to enable the ARMED timeout.
module ballot_unit #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LOCKOUT_CYCLES  = 32,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic CLK,
    input  logic CLEAR_N,
    input  logic ENABLE,
    input  logic BTN_P1,
    input  logic BTN_P2,
    input  logic BTN_P3,
    input  logic BTN_NOTA,
    output logic P1,
    output logic P2,
    output logic P3,
    output logic NOTA,
    output logic READY,
    output logic BUSY,
    output logic ERR_MULTI,
    output logic TIMEOUT
);

    import ballot_pkg::*;

    localparam int HCW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(LOCKOUT_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [NUM_BUTTONS-1:0] btn_raw;
    logic [NUM_BUTTONS-1:0] db_lvl;
    logic [NUM_BUTTONS-1:0] sel_q, sel_d;
    logic [NUM_BUTTONS-1:0] strobe_q, strobe_d;
    logic                   seen_q, seen_d;
    logic                   err_q, err_d;
    logic [HCW-1:0]         hold_cnt_q, hold_cnt_d;
    logic [2:0]             num_high;
    logic                   any_high;
    logic                   press_ok;
    logic                   multi;
    logic                   tmo_expire;

    assign btn_raw[CAND_P1]   = BTN_P1;
    assign btn_raw[CAND_P2]   = BTN_P2;
    assign btn_raw[CAND_P3]   = BTN_P3;
    assign btn_raw[CAND_NOTA] = BTN_NOTA;

    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
        ballot_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_i  (CLK),
            .rst_ni (CLEAR_N),
            .btn_i  (btn_raw[gi]),
            .level_o(db_lvl[gi])
        );
    end

    assign num_high = count_high(db_lvl);
    assign any_high = |db_lvl;
    // Presses only count once every button has been seen released in this
    // ballot, so a button held across ENABLE cannot vote.
    assign press_ok = (state_q == ARMED) && seen_q && (num_high == 3'd1);
    assign multi    = (state_q == ARMED) && seen_q && (num_high >= 3'd2);

`ifdef VOTE_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);

    logic [TCW-1:0] tmo_cnt_q;
    logic           timeout_q;

    assign tmo_expire = (state_q == ARMED) && (tmo_cnt_q == TMO_LAST);

    // Held at zero outside ARMED, so it reads 0 on the first ARMED cycle.
    // A valid press on the expiry cycle takes priority over the timeout.
    always_ff @(posedge CLK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q != ARMED) begin
                tmo_cnt_q <= '0;
            end else if (tmo_cnt_q != TMO_LAST) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            timeout_q <= tmo_expire && !press_ok;
        end
    end

    assign TIMEOUT = timeout_q;
`else
    assign tmo_expire = 1'b0;
    assign TIMEOUT    = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ENABLE) state_d = ARMED;
            ARMED: begin
                if (press_ok) begin
                    state_d = CAST;
                end else if (tmo_expire) begin
                    state_d = IDLE;
                end
            end
            CAST:    state_d = HOLD;
            HOLD:    if ((hold_cnt_q >= HOLD_LAST) && !any_high) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ballot bookkeeping next-state
    always_comb begin
        seen_d     = seen_q;
        err_d      = err_q;
        sel_d      = sel_q;
        hold_cnt_d = hold_cnt_q;
        // Strobe register fires for exactly the cycle after CAST.
        strobe_d   = (state_q == CAST) ? sel_q : '0;
        case (state_q)
            IDLE: begin
                if (ENABLE) begin
                    seen_d = 1'b0;
                    err_d  = 1'b0;
                end
            end
            ARMED: begin
                if (multi) begin
                    err_d  = 1'b1;
                    seen_d = 1'b0;
                end else if (!any_high) begin
                    seen_d = 1'b1;
                end
                if (press_ok) begin
                    sel_d = db_lvl;
                end
            end
            CAST:    hold_cnt_d = '0;
            HOLD: begin
                if (hold_cnt_q < HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            seen_q     <= 1'b0;
            err_q      <= 1'b0;
            sel_q      <= '0;
            hold_cnt_q <= '0;
            strobe_q   <= '0;
        end else begin
            seen_q     <= seen_d;
            err_q      <= err_d;
            sel_q      <= sel_d;
            hold_cnt_q <= hold_cnt_d;
            strobe_q   <= strobe_d;
        end
    end

    // Outputs
    always_comb begin
        READY     = (state_q == ARMED);
        BUSY      = (state_q == HOLD);
        ERR_MULTI = err_q;
        P1        = strobe_q[CAND_P1];
        P2        = strobe_q[CAND_P2];
        P3        = strobe_q[CAND_P3];
        NOTA      = strobe_q[CAND_NOTA];
    end

endmodule
